// File: rtl/lc4_limb_alu.sv
`default_nettype none
// ============================================================================
// Module      : lc4_limb_alu
// Description : Limb-serial WORD_SIZE-bit ALU for the LC4 arithmetic ops.
//               Processes LIMB_WIDTH bits per cycle (LSB limb first) using
//               captured operands and a registered inter-limb carry.
//               Optional zero flag: define LC4_LIMB_ALU_ZERO_FLAG_EN.
//               WORD_SIZE must be an integer multiple of LIMB_WIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
module lc4_limb_alu #(
   parameter int WORD_SIZE  = 256,
   parameter int LIMB_WIDTH = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [4:0]           i_op,
   input  logic [WORD_SIZE-1:0] i_r1data,
   input  logic [WORD_SIZE-1:0] i_r2data,
   input  logic [4:0]           i_imm5,
   input  logic                 i_carry,
   output logic                 o_valid,
   output logic [WORD_SIZE-1:0] o_result,
   output logic                 o_carry,
   output logic                 o_err
`ifdef LC4_LIMB_ALU_ZERO_FLAG_EN
   ,
   output logic                 o_zero
`endif
);

   localparam int NUM_LIMBS = WORD_SIZE / LIMB_WIDTH;
   localparam int CNT_W     = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;
   localparam logic [CNT_W-1:0] c_last_limb = CNT_W'(NUM_LIMBS - 1);

   localparam logic [1:0] c_st_idle = 2'd0;
   localparam logic [1:0] c_st_busy = 2'd1;
   localparam logic [1:0] c_st_done = 2'd2;

   localparam logic [4:0] c_op_add  = 5'b00101;
   localparam logic [4:0] c_op_sub  = 5'b00110;
   localparam logic [4:0] c_op_addi = 5'b00111;
   localparam logic [4:0] c_op_and  = 5'b01001;
   localparam logic [4:0] c_op_xmp  = 5'b10011;
   localparam logic [4:0] c_op_tcs  = 5'b10100;
   localparam logic [4:0] c_op_tcdh = 5'b10101;

   // Per-limb combine: adder, bitwise AND or bitwise XOR of the captured a/b.
   localparam logic [1:0] c_kind_arith = 2'd0;
   localparam logic [1:0] c_kind_and   = 2'd1;
   localparam logic [1:0] c_kind_xor   = 2'd2;

   logic [1:0]            r_state;
   logic [1:0]            w_next_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [WORD_SIZE-1:0]  r_a;
   logic [WORD_SIZE-1:0]  r_b;
   logic                  r_c;
   logic [1:0]            r_kind;
   logic                  r_arith;
   logic                  r_err;
   logic [WORD_SIZE-1:0]  r_acc;

   logic                  w_accept;
   logic                  w_busy;
   logic                  w_last;
   logic [WORD_SIZE-1:0]  w_imm_sext;
   logic [WORD_SIZE-1:0]  w_dec_a;
   logic [WORD_SIZE-1:0]  w_dec_b;
   logic                  w_dec_cin;
   logic [1:0]            w_dec_kind;
   logic                  w_dec_arith;
   logic                  w_dec_err;
   logic [LIMB_WIDTH:0]   w_sum;
   logic [LIMB_WIDTH-1:0] w_limb;
   logic [WORD_SIZE-1:0]  w_acc_next;

   assign w_accept   = i_valid & o_ready;
   assign w_busy     = (r_state == c_st_busy);
   assign w_last     = (r_cnt == c_last_limb);
   assign w_imm_sext = WORD_SIZE'($signed(i_imm5));

   // Opcode decode into adder/logic operands so BUSY only needs the limb slice.
   always_comb begin
      w_dec_a     = i_r1data;
      w_dec_b     = '0;
      w_dec_cin   = 1'b0;
      w_dec_kind  = c_kind_arith;
      w_dec_arith = 1'b0;
      w_dec_err   = 1'b0;
      case (i_op)
         c_op_add:  begin w_dec_b = i_r2data;   w_dec_arith = 1'b1; end
         c_op_addi: begin w_dec_b = w_imm_sext; w_dec_arith = 1'b1; end
         c_op_sub:  begin w_dec_b = ~i_r2data;  w_dec_cin = 1'b1; w_dec_arith = 1'b1; end
         c_op_tcs:  begin w_dec_a = ~i_r1data;  w_dec_cin = 1'b1; w_dec_arith = 1'b1; end
         c_op_tcdh: begin
            // Pass-through is rs + 0 + 0, which never carries out.
            if (i_carry) begin
               w_dec_a   = ~i_r1data;
               w_dec_cin = 1'b1;
            end
            w_dec_arith = i_carry;
         end
         c_op_and:  begin w_dec_b = w_imm_sext; w_dec_kind = c_kind_and; end
         c_op_xmp:  begin w_dec_b = i_r2data;   w_dec_kind = c_kind_xor; end
         default:   begin w_dec_a = '0; w_dec_kind = c_kind_and; w_dec_err = 1'b1; end
      endcase
   end

   // Current limb result from the low slice of the shifting operand registers.
   always_comb begin
      w_sum = {1'b0, r_a[LIMB_WIDTH-1:0]} + {1'b0, r_b[LIMB_WIDTH-1:0]}
            + {{LIMB_WIDTH{1'b0}}, r_c};
      case (r_kind)
         c_kind_and: w_limb = r_a[LIMB_WIDTH-1:0] & r_b[LIMB_WIDTH-1:0];
         c_kind_xor: w_limb = r_a[LIMB_WIDTH-1:0] ^ r_b[LIMB_WIDTH-1:0];
         default:    w_limb = w_sum[LIMB_WIDTH-1:0];
      endcase
   end

   // Each finished limb enters the accumulator at the top and moves down.
   generate
      if (NUM_LIMBS == 1) begin : g_acc_single
         assign w_acc_next = w_limb;
      end else begin : g_acc_multi
         assign w_acc_next = {w_limb, r_acc[WORD_SIZE-1:LIMB_WIDTH]};
      end
   endgenerate

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= c_st_idle;
      else     r_state <= w_next_state;
   end

   // Next-state logic: DONE may accept directly for bubble-free streaming.
   always_comb begin
      w_next_state = c_st_idle;
      case (r_state)
         c_st_idle: w_next_state = w_accept ? c_st_busy : c_st_idle;
         c_st_busy: w_next_state = w_last   ? c_st_done : c_st_busy;
         c_st_done: w_next_state = w_accept ? c_st_busy : c_st_idle;
         default:   w_next_state = c_st_idle;
      endcase
   end

   // Handshake outputs decoded from state.
   always_comb begin
      o_ready = (r_state != c_st_busy);
      o_valid = (r_state == c_st_done);
   end

   // Operand capture at accept, limb shifting and carry chaining while BUSY.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= '0;
         r_c     <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_kind  <= c_kind_arith;
         r_arith <= 1'b0;
         r_err   <= 1'b0;
         r_acc   <= '0;
      end else if (w_accept) begin
         r_cnt   <= '0;
         r_c     <= w_dec_cin;
         r_a     <= w_dec_a;
         r_b     <= w_dec_b;
         r_kind  <= w_dec_kind;
         r_arith <= w_dec_arith;
         r_err   <= w_dec_err;
      end else if (w_busy) begin
         r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
         r_c     <= w_sum[LIMB_WIDTH];
         r_a     <= r_a >> LIMB_WIDTH;
         r_b     <= r_b >> LIMB_WIDTH;
         r_acc   <= w_acc_next;
      end
   end

   // Result registers load only when the last limb completes.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_result <= '0;
         o_carry  <= 1'b0;
         o_err    <= 1'b0;
      end else if (w_busy && w_last) begin
         o_result <= w_acc_next;
         o_carry  <= r_arith & w_sum[LIMB_WIDTH];
         o_err    <= r_err;
      end
   end

`ifdef LC4_LIMB_ALU_ZERO_FLAG_EN
   logic r_nz;

   // Zero flag: OR-reduce each limb into a sticky non-zero bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_nz   <= 1'b0;
         o_zero <= 1'b0;
      end else if (w_accept) begin
         r_nz   <= 1'b0;
      end else if (w_busy) begin
         r_nz <= r_nz | (|w_limb);
         if (w_last) o_zero <= ~(r_nz | (|w_limb));
      end
   end
`else
   // Zero flag not built: no extra state or port.
`endif

endmodule
`default_nettype wire
